// File: rtl/pmem_line_responder.sv
// pmem_line_responder: line-granular pmem responder backed by an internal line array
module pmem_line_responder #(
  parameter int LINE_WIDTH  = 256,
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 5,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [31:0]           pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  pmem_resp,
  output logic                  protocol_err,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t                  state_q;
  logic [7:0]              cnt_q;
  logic                    op_wr_q;
  logic [INDEX_BITS-1:0]   idx_q;
  logic [INDEX_BITS-1:0]   idx_d;
  logic [LINE_WIDTH-1:0]   wdata_q;
  logic [LINE_WIDTH-1:0]   rdata_q;
  logic                    resp_q;
  logic                    err_q;
  logic [15:0]             rd_cnt_q;
  logic [15:0]             wr_cnt_q;
  logic                    held_d;
  logic [LINE_WIDTH-1:0]   mem_q [2**INDEX_BITS];
  assign idx_d  = pmem_address[OFFSET_BITS +: INDEX_BITS];
  assign held_d = op_wr_q ? pmem_write : pmem_read;
  // Every latency runs through BUSY so the response always lands LATENCY edges after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_wr_q  <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      resp_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        IDLE: if (pmem_read || pmem_write) begin
          op_wr_q <= pmem_write;
          idx_q   <= idx_d;
          wdata_q <= pmem_wdata;
          cnt_q   <= 8'(LATENCY - 1);
          state_q <= BUSY;
          if (pmem_read && pmem_write) err_q <= 1'b1;
        end
        BUSY: if (!held_d) begin
          state_q <= IDLE;
          err_q   <= 1'b1;
        end else if (cnt_q == 8'd0) begin
          state_q <= RESP;
          resp_q  <= 1'b1;
          if (!op_wr_q) rdata_q <= mem_q[idx_q];
        end else begin
          cnt_q <= cnt_q - 8'd1;
        end
        RESP: begin
          state_q <= IDLE;
          if (op_wr_q) wr_cnt_q <= wr_cnt_q + {15'd0, wr_cnt_q != 16'hFFFF};
          else         rd_cnt_q <= rd_cnt_q + {15'd0, rd_cnt_q != 16'hFFFF};
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // The array is never reset; a reset during RESP pulls state_q out of RESP before the commit edge.
  always_ff @(posedge clk) begin
    if (state_q == RESP && op_wr_q) mem_q[idx_q] <= wdata_q;
  end
  assign pmem_rdata   = rdata_q;
  assign pmem_resp    = resp_q;
  assign protocol_err = err_q;
  assign rd_count     = rd_cnt_q;
  assign wr_count     = wr_cnt_q;
endmodule
